conv_layer_sequencer: RTL

Per-sample scheduler for a stack of NUM_LAYERS dilated causal conv layers with kernel size 4. Each layer has its own activation cache, and all layers share one MAC engine. On each accepted input sample the block advances each layer's cache in turn, starts the shared MAC for that layer, and waits for it to finish. After the last layer it emits out_valid. It also tracks warm-up (receptive field filled), overruns and MAC timeouts.

---
 rtl/conv_layer_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/conv_layer_sequencer.sv
// Per-sample scheduler for a stack of dilated causal conv layers sharing one MAC.
// Walks ADV -> START -> WAIT for each layer, then pulses out_valid; tracks warm-up and errors.
module conv_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [NUM_LAYERS-1:0]         cache_adv,
    output logic                          mac_start,
    input  logic                          mac_done,
    output logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
    output logic [2*NUM_LAYERS-2:0]       layer_dilation,
    output logic                          out_valid,
    output logic                          primed,
    output logic                          busy,
    output logic                          overrun,
    output logic                          timeout_err,
    output logic [CNT_W-1:0]              drop_count,
    input  logic                          err_clr
);

    localparam int LW    = $clog2(NUM_LAYERS);
    localparam int DW    = 2 * NUM_LAYERS - 1;
    localparam int WW    = $clog2(TIMEOUT + 1);
    localparam int PRIME = 4 ** NUM_LAYERS;
    localparam int SW    = $clog2(PRIME + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADV, S_START, S_WAIT, S_DONE} state_t;

    state_t                  state_reg, state_next;
    logic [LW-1:0]           layer_idx_reg, layer_idx_next;
    logic [WW-1:0]           wait_cnt_reg, wait_cnt_next;
    logic [SW-1:0]           sample_cnt_reg, sample_cnt_next;
    logic [NUM_LAYERS-1:0]   cache_adv_reg, adv_dec;
    logic                    mac_start_reg, mac_start_next;
    logic                    out_valid_reg, out_valid_next;
    logic                    overrun_reg, overrun_next;
    logic                    timeout_err_reg, timeout_err_next;
    logic [CNT_W-1:0]        drop_count_reg, drop_count_next;
    logic                    accept, overrun_evt, timeout_evt;

    assign sample_ready = (state_reg == S_IDLE);
    assign accept       = sample_valid && sample_ready;
    assign overrun_evt  = sample_valid && !sample_ready;

    always_comb begin
        state_next       = state_reg;
        layer_idx_next   = layer_idx_reg;
        wait_cnt_next    = wait_cnt_reg;
        timeout_evt      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    layer_idx_next = '0;
                    state_next     = S_ADV;
                end
            end
            S_ADV:   state_next = S_START;
            S_START: begin
                wait_cnt_next = '0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the last permitted cycle still wins over the abort.
                if (mac_done) begin
                    if (layer_idx_reg == LW'(NUM_LAYERS - 1)) begin
                        state_next = S_DONE;
                    end else begin
                        layer_idx_next = layer_idx_reg + LW'(1);
                        state_next     = S_ADV;
                    end
                end else if (wait_cnt_reg == WW'(TIMEOUT - 1)) begin
                    timeout_evt = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WW'(1);
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        mac_start_next = (state_next == S_START);
        out_valid_next = (state_next == S_DONE);

        sample_cnt_next = sample_cnt_reg;
        if (accept && sample_cnt_reg != SW'(PRIME))
            sample_cnt_next = sample_cnt_reg + SW'(1);

        // New events take priority over a simultaneous clear.
        overrun_next     = overrun_evt | (overrun_reg & ~err_clr);
        timeout_err_next = timeout_evt | (timeout_err_reg & ~err_clr);
        drop_count_next  = drop_count_reg;
        if (overrun_evt) begin
            if (err_clr)
                drop_count_next = CNT_W'(1);
            else if (!(&drop_count_reg))
                drop_count_next = drop_count_reg + CNT_W'(1);
        end else if (err_clr) begin
            drop_count_next = '0;
        end
    end

    // Registered one-hot advance strobe, decoded from the upcoming state.
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_adv
        assign adv_dec[gi] = (state_next == S_ADV) && (layer_idx_next == LW'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            layer_idx_reg   <= '0;
            wait_cnt_reg    <= '0;
            sample_cnt_reg  <= '0;
            cache_adv_reg   <= '0;
            mac_start_reg   <= 1'b0;
            out_valid_reg   <= 1'b0;
            overrun_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            drop_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            layer_idx_reg   <= layer_idx_next;
            wait_cnt_reg    <= wait_cnt_next;
            sample_cnt_reg  <= sample_cnt_next;
            cache_adv_reg   <= adv_dec;
            mac_start_reg   <= mac_start_next;
            out_valid_reg   <= out_valid_next;
            overrun_reg     <= overrun_next;
            timeout_err_reg <= timeout_err_next;
            drop_count_reg  <= drop_count_next;
        end
    end

    assign cache_adv      = cache_adv_reg;
    assign mac_start      = mac_start_reg;
    assign out_valid      = out_valid_reg;
    assign layer_idx      = layer_idx_reg;
    assign layer_dilation = {{(DW-1){1'b0}}, 1'b1} << {layer_idx_reg, 1'b0};
    assign primed         = (sample_cnt_reg == SW'(PRIME));
    assign busy           = (state_reg != S_IDLE);
    assign overrun        = overrun_reg;
    assign timeout_err    = timeout_err_reg;
    assign drop_count     = drop_count_reg;

endmodule
